// File: rtl/axi_lite_wr_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite write and read slaves:
//   - response codes placed on BRESP / RRESP
//   - write-response channel state type
//   - reset_word(): power-on contents of every memory word (index * 5)
// No ports (package).
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write-response channel: idle (accepting AW/W) or presenting a response.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } b_state_e;

  // Reset contents of memory word idx. The read slave uses the same map.
  function automatic logic [31:0] reset_word(input int idx);
    return 32'(idx) * 32'd5;
  endfunction

endpackage

// File: rtl/axi_lite_wr_slave_if.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_slave_if
// AXI4-Lite write-side bus bundle (AW, W and B channels).
// Parameters: ADDR_W address width, DATA_W data width (multiple of 8).
// Modports:
//   slave  - receives AW/W, drives the ready signals and the B channel
//   master - drives AW/W and bready, receives the ready signals and B
// -----------------------------------------------------------------------------
interface axi_lite_wr_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  localparam int STRB_W = DATA_W / 8;

  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [1:0]        s_axi_bresp;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    input  s_axi_bready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bvalid, s_axi_bresp
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    output s_axi_bready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bvalid, s_axi_bresp
  );

endinterface

// File: rtl/axi_lite_wr_slave_chan_reg.sv
// -----------------------------------------------------------------------------
// axi_lite_chan_reg
// One-entry holding register for an AXI valid/ready channel.
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_valid         channel valid from the master
//   i_data          channel payload, captured on handshake
//   i_clr           empties the entry (consumer has used it)
//   i_hold_nxt      keep ready low next cycle regardless of the full flag
//   o_ready         registered ready; depends only on next-state, never on
//                   i_valid/i_data directly
//   o_full          entry holds a captured payload
//   o_data          captured payload
// -----------------------------------------------------------------------------
module axi_lite_chan_reg
  import axi_lite_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_clr,
  input  logic         i_hold_nxt,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         w_hs;
  logic         w_full_nxt;
  logic         r_full;
  logic         r_ready;
  logic [W-1:0] r_data;

  // Handshake detection and next value of the full flag.
  always_comb begin
    w_hs       = i_valid && r_ready;
    w_full_nxt = r_full;
    if (i_clr) begin
      w_full_nxt = 1'b0;
    end else if (w_hs) begin
      w_full_nxt = 1'b1;
    end else begin
      w_full_nxt = r_full;
    end
  end

  // Entry state; ready is derived from the next state so it drops on the
  // very edge that fills the entry and a second capture cannot happen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= {W{1'b0}};
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= !w_full_nxt && !i_hold_nxt;
      if (w_hs) begin
        r_data <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_wr_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_slave
// AXI4-Lite write slave terminating writes into a word-addressed register
// memory with byte strobes. One transaction outstanding at a time.
// Parameters: DATA_W data width, ADDR_W address width, DEPTH memory words.
// Ports:
//   s_axi_aclk      clock, rising edge
//   s_axi_aresetn   asynchronous active-low reset
//   s_axi           AW/W/B bus (slave modport)
//   dbg_addr        debug read index
//   dbg_data        mem[dbg_addr], combinational
//   wr_count        number of committed in-range writes (wraps at 16 bits)
// -----------------------------------------------------------------------------
module axi_lite_wr_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  axi_lite_wr_slave_if.slave       s_axi,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [15:0]              wr_count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);

  b_state_e           r_state;
  b_state_e           w_state_nxt;
  logic               w_commit;
  logic               w_hold_nxt;
  logic               w_in_range;
  logic [IDX_W-1:0]   w_idx;

  logic               w_aw_ready;
  logic               w_aw_full;
  logic [ADDR_W-1:0]  w_aw_addr;
  logic               w_w_ready;
  logic               w_w_full;
  logic [DATA_W+STRB_W-1:0] w_w_bundle;
  logic [DATA_W-1:0]  w_wdata;
  logic [STRB_W-1:0]  w_wstrb;

  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic [15:0]        r_wr_count;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  // Both channel entries are held closed while a response is pending next
  // cycle, so nothing new is accepted until the B handshake completes.
  axi_lite_chan_reg #(.W(ADDR_W)) u_aw_reg (
    .i_clk      (s_axi_aclk),
    .i_rst_n    (s_axi_aresetn),
    .i_valid    (s_axi.s_axi_awvalid),
    .i_data     (s_axi.s_axi_awaddr),
    .i_clr      (w_commit),
    .i_hold_nxt (w_hold_nxt),
    .o_ready    (w_aw_ready),
    .o_full     (w_aw_full),
    .o_data     (w_aw_addr)
  );

  axi_lite_chan_reg #(.W(DATA_W + STRB_W)) u_w_reg (
    .i_clk      (s_axi_aclk),
    .i_rst_n    (s_axi_aresetn),
    .i_valid    (s_axi.s_axi_wvalid),
    .i_data     ({s_axi.s_axi_wstrb, s_axi.s_axi_wdata}),
    .i_clr      (w_commit),
    .i_hold_nxt (w_hold_nxt),
    .o_ready    (w_w_ready),
    .o_full     (w_w_full),
    .o_data     (w_w_bundle)
  );

  assign w_wdata    = w_w_bundle[DATA_W-1:0];
  assign w_wstrb    = w_w_bundle[DATA_W+STRB_W-1:DATA_W];
  assign w_in_range = (w_aw_addr < ADDR_W'(DEPTH));
  assign w_idx      = w_aw_addr[IDX_W-1:0];

  // Response FSM next state: commit when both entries are full, leave the
  // response state once bready is sampled high.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_aw_full && w_w_full) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (s_axi.s_axi_bready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_hold_nxt = (w_state_nxt == ST_RESP);
  end

  // Response FSM state and registered B-channel outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state  <= ST_IDLE;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_state  <= w_state_nxt;
      r_bvalid <= (w_state_nxt == ST_RESP);
      if (w_commit) begin
        r_bresp <= w_in_range ? RESP_OKAY : RESP_DECERR;
      end else if (r_bvalid && s_axi.s_axi_bready) begin
        r_bresp <= RESP_OKAY;
      end
    end
  end

  // Committed-write counter; only in-range writes count.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wr_count <= 16'd0;
    end else if (w_commit && w_in_range) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  // Register memory: reset image plus byte-strobed writes on commit.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(reset_word(i));
      end
    end else if (w_commit && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign s_axi.s_axi_awready = w_aw_ready;
  assign s_axi.s_axi_wready  = w_w_ready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign dbg_data            = r_mem[dbg_addr];
  assign wr_count            = r_wr_count;

endmodule

// File: tb/tb_axi_lite_wr_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_wr_slave
// Drives directed and random AXI4-Lite writes. Each issued write pushes its
// expected response (bresp, wr_count, debug word) into a scoreboard queue; an
// independent monitor pops and compares whenever bvalid rises.
// -----------------------------------------------------------------------------
module tb_axi_lite_wr_slave;
  import axi_lite_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;

  typedef struct {
    logic [1:0]  resp;
    logic [15:0] count;
    logic [31:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  dbg_addr = 4'd0;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  axi_lite_wr_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_wr_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus.slave),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          last_hs = 0;
  exp_t        sb[$];
  logic [31:0] m_mem [DEPTH];
  logic [15:0] m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'(i * 5);
    m_count = 16'd0;
    sb.delete();
  endtask

  // Reference: strobed bytes replace, others keep; out of range is a no-op.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [3:0] di,
                             output exp_t e);
    logic [31:0] mask;
    mask = 32'd0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    if (a < DEPTH) begin
      m_mem[a[3:0]] = (m_mem[a[3:0]] & ~mask) | (d & mask);
      m_count = m_count + 16'd1;
      e.resp = 2'b00;
    end else begin
      e.resp = 2'b11;
    end
    e.count = m_count;
    e.word  = m_mem[di];
  endtask

  // Monitor: compare the response presented on each rising bvalid.
  initial begin : monitor
    exp_t e;
    bit   prev_bv;
    prev_bv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_bv = 1'b0;
      end else begin
        if (bus.s_axi_bvalid && !prev_bv) begin
          if (sb.size() == 0) begin
            check("unexpected_bvalid", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("bresp", 64'(bus.s_axi_bresp), 64'(e.resp));
            check("wr_count", 64'(wr_count), 64'(e.count));
            check("dbg_data", 64'(dbg_data), 64'(e.word));
            check("b_latency", 64'(cyc), 64'(last_hs + 1));
          end
        end
        prev_bv = bus.s_axi_bvalid;
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    bit done;
    done = 1'b0;
    @(negedge clk);
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_awaddr  = a;
    for (int t = 0; t < 50 && !done; t++) begin
      if (bus.s_axi_awready) begin
        last_hs = cyc + 1;
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.s_axi_awvalid = 1'b0;
    if (!done) check("aw_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit done;
    done = 1'b0;
    @(negedge clk);
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_wdata  = d;
    bus.s_axi_wstrb  = s;
    for (int t = 0; t < 50 && !done; t++) begin
      if (bus.s_axi_wready) begin
        last_hs = cyc + 1;
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.s_axi_wvalid = 1'b0;
    if (!done) check("w_handshake_timeout", 64'd0, 64'd1);
  endtask

  // order: 0 same cycle, 1 AW then W after gap, 2 W then AW after gap.
  // bp: cycles bready is held low after bvalid rises.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int order, input int gap, input int bp);
    exp_t e;
    bit   seen;
    logic [3:0] di;
    di = (a < DEPTH) ? a[3:0] : 4'($urandom_range(0, 15));
    dbg_addr = di;
    bus.s_axi_bready = (bp == 0);
    model_write(a, d, s, di, e);
    sb.push_back(e);
    case (order)
      0: fork send_aw(a); send_w(d, s); join
      1: begin
        send_aw(a);
        repeat (gap) begin
          @(negedge clk);
          check("awready_low_while_full", 64'(bus.s_axi_awready), 64'd0);
        end
        send_w(d, s);
      end
      default: begin
        send_w(d, s);
        repeat (gap) @(negedge clk);
        send_aw(a);
      end
    endcase
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = bus.s_axi_bvalid;
    end
    if (!seen) begin
      check("bvalid_timeout", 64'd0, 64'd1);
    end else begin
      for (int k = 0; k < bp; k++) begin
        check("bp_bvalid", 64'(bus.s_axi_bvalid), 64'd1);
        check("bp_bresp", 64'(bus.s_axi_bresp), 64'(e.resp));
        check("bp_ready", 64'({bus.s_axi_awready, bus.s_axi_wready}), 64'd0);
        @(negedge clk);
      end
      bus.s_axi_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("b_done_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
      check("b_done_bresp", 64'(bus.s_axi_bresp), 64'd0);
      seen = 1'b0;
      for (int t = 0; t < 3 && !seen; t++) begin
        seen = bus.s_axi_awready && bus.s_axi_wready;
        if (!seen) @(negedge clk);
      end
      check("ready_return", 64'(seen), 64'd1);
    end
    bus.s_axi_bready = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    bit quiet;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_awaddr  = 32'd0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_wdata   = 32'd0;
    bus.s_axi_wstrb   = 4'd0;
    bus.s_axi_bready  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(bus.s_axi_awready), 64'd0);
    check("rst_wready", 64'(bus.s_axi_wready), 64'd0);
    check("rst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
    check("rst_bresp", 64'(bus.s_axi_bresp), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("rst_mem", 64'(dbg_data), 64'(i * 5));
    end

    // Directed cases
    do_txn(32'd3, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_txn(32'd5, 32'h11223344, 4'h5, 1, 4, 0);
    dbg_addr = 4'd5;
    #1;
    check("strobe_merge_mem5", 64'(dbg_data), 64'h00220044);
    do_txn(32'd0, 32'hA5A5A5A5, 4'hF, 2, 3, 0);
    do_txn(32'd16, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    dbg_addr = 4'd15;
    #1;
    check("oor_mem15", 64'(dbg_data), 64'd75);
    check("oor_wr_count", 64'(wr_count), 64'd3);
    do_txn(32'd7, 32'h0BADF00D, 4'hF, 0, 0, 5);
    do_txn(32'd9, 32'h12345678, 4'h0, 1, 1, 2);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      do_txn(32'($urandom_range(0, 19)), $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
    end

    // Memory image against the model
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("sweep_mem", 64'(dbg_data), 64'(m_mem[i]));
    end

    // Reset with AW captured but no W: transaction discarded
    dbg_addr = 4'd2;
    send_aw(32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'({bus.s_axi_awready, bus.s_axi_wready}), 64'd0);
    check("midrst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
    check("midrst_wr_count", 64'(wr_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_w(32'hCAFEF00D, 4'hF);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.s_axi_bvalid) quiet = 1'b0;
    end
    check("midrst_no_response", 64'(quiet), 64'd1);
    check("midrst_mem2", 64'(dbg_data), 64'd10);
    check("midrst_count_after", 64'(wr_count), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("midrst_sweep", 64'(dbg_data), 64'(m_mem[i]));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
